// File: rtl/pacman_pkg.sv
// Shared direction type, PS/2 scan-code constants and decode helpers for pacman control.
package pacman_pkg;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  typedef enum logic [1:0] {
    PS_IDLE    = 2'd0,
    PS_EXT     = 2'd1,
    PS_BRK     = 2'd2,
    PS_EXT_BRK = 2'd3
  } ps2_state_t;

  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_BRK     = 8'hF0;
  localparam logic [7:0] SC_UP      = 8'h1D;
  localparam logic [7:0] SC_DOWN    = 8'h1B;
  localparam logic [7:0] SC_LEFT    = 8'h1C;
  localparam logic [7:0] SC_RIGHT   = 8'h23;
  localparam logic [7:0] SC_E_UP    = 8'h75;
  localparam logic [7:0] SC_E_DOWN  = 8'h72;
  localparam logic [7:0] SC_E_LEFT  = 8'h6B;
  localparam logic [7:0] SC_E_RIGHT = 8'h74;

  // Single-byte (WASD-style) make codes
  function automatic dir_t decode_base(input logic [7:0] code);
    dir_t d;
    case (code)
      SC_UP:    d = DIR_UP;
      SC_DOWN:  d = DIR_DOWN;
      SC_LEFT:  d = DIR_LEFT;
      SC_RIGHT: d = DIR_RIGHT;
      default:  d = DIR_NONE;
    endcase
    return d;
  endfunction

  // Arrow-key make codes following an E0 prefix
  function automatic dir_t decode_ext(input logic [7:0] code);
    dir_t d;
    case (code)
      SC_E_UP:    d = DIR_UP;
      SC_E_DOWN:  d = DIR_DOWN;
      SC_E_LEFT:  d = DIR_LEFT;
      SC_E_RIGHT: d = DIR_RIGHT;
      default:    d = DIR_NONE;
    endcase
    return d;
  endfunction

  function automatic dir_t opposite(input dir_t d);
    dir_t o;
    case (d)
      DIR_UP:    o = DIR_DOWN;
      DIR_DOWN:  o = DIR_UP;
      DIR_LEFT:  o = DIR_RIGHT;
      DIR_RIGHT: o = DIR_LEFT;
      default:   o = DIR_NONE;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/ps2_byte_parser.sv
// PS/2 scan-byte parser: tracks E0/F0 prefixes, emits a make strobe with its direction,
// and abandons a partial multi-byte code after TIMEOUT_CYCLES of silence.
module ps2_byte_parser
  import pacman_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       make_c,
  output dir_t       make_dir_c,
  output logic       frame_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ps2_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             frame_err_nxt;

  // Make decode is combinational so the consumer can register it on the strobe edge
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    frame_err_nxt = 1'b0;
    make_c        = 1'b0;
    make_dir_c    = DIR_NONE;
    if (byte_valid) begin
      cnt_nxt = '0;
      case (state)
        PS_IDLE: begin
          if (byte_data == SC_EXT) begin
            state_nxt = PS_EXT;
          end else if (byte_data == SC_BRK) begin
            state_nxt = PS_BRK;
          end else begin
            make_dir_c = decode_base(byte_data);
            make_c     = (make_dir_c != DIR_NONE);
          end
        end
        PS_EXT: begin
          if (byte_data == SC_BRK) begin
            state_nxt = PS_EXT_BRK;
          end else begin
            state_nxt  = PS_IDLE;
            make_dir_c = decode_ext(byte_data);
            make_c     = (make_dir_c != DIR_NONE);
          end
        end
        default: state_nxt = PS_IDLE;
      endcase
    end else if (state != PS_IDLE) begin
      if (cnt == CNT_LAST) begin
        state_nxt     = PS_IDLE;
        cnt_nxt       = '0;
        frame_err_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= PS_IDLE;
      cnt       <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      frame_err <= frame_err_nxt;
    end
  end

endmodule

// File: rtl/move_cmd_buffer.sv
// Buffers keyboard direction requests and commits them to pacman's heading at tile
// boundaries; starts from stop and reversals take effect immediately.
module move_cmd_buffer
  import pacman_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       step_done,
  input  logic       turn_ok,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       pend_valid,
  output logic       frame_err
);

  logic make_c;
  dir_t make_dir_c;
  dir_t req_dir, req_nxt;
  dir_t cur_dir, cur_nxt;

  ps2_byte_parser #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_parser (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .make_c    (make_c),
    .make_dir_c(make_dir_c),
    .frame_err (frame_err)
  );

  // Tile-boundary commit uses the old request; an immediate make overrides it
  always_comb begin
    req_nxt = req_dir;
    cur_nxt = cur_dir;
    if (step_done && turn_ok && (req_dir != DIR_NONE)) begin
      cur_nxt = req_dir;
    end
    if (make_c) begin
      req_nxt = make_dir_c;
      if ((cur_dir == DIR_NONE) || (make_dir_c == opposite(cur_dir))) begin
        cur_nxt = make_dir_c;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      req_dir    <= DIR_NONE;
      cur_dir    <= DIR_NONE;
      up         <= 1'b0;
      down       <= 1'b0;
      left       <= 1'b0;
      right      <= 1'b0;
      pend_valid <= 1'b0;
    end else begin
      req_dir    <= req_nxt;
      cur_dir    <= cur_nxt;
      up         <= (cur_nxt == DIR_UP);
      down       <= (cur_nxt == DIR_DOWN);
      left       <= (cur_nxt == DIR_LEFT);
      right      <= (cur_nxt == DIR_RIGHT);
      pend_valid <= (req_nxt != DIR_NONE) && (req_nxt != cur_nxt);
    end
  end

endmodule

// File: tb/tb_move_cmd_buffer.sv
// Scoreboard bench for move_cmd_buffer: each driven cycle queues the expected outputs,
// a negedge monitor pops and compares them.
module tb_move_cmd_buffer;

  localparam int unsigned TB_TIMEOUT = 64;

  localparam logic [5:0] O_UP = 6'b100000;
  localparam logic [5:0] O_DN = 6'b010000;
  localparam logic [5:0] O_LF = 6'b001000;
  localparam logic [5:0] O_RT = 6'b000100;
  localparam logic [5:0] O_PV = 6'b000010;
  localparam logic [5:0] O_FE = 6'b000001;
  localparam logic [5:0] O_NO = 6'b000000;

  logic       CLOCK_50   = 1'b0;
  logic       reset_n    = 1'b1;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data  = 8'h00;
  logic       step_done  = 1'b0;
  logic       turn_ok    = 1'b0;
  logic       up, down, left, right, pend_valid, frame_err;

  typedef struct {
    logic [5:0] v;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  move_cmd_buffer #(
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .step_done (step_done),
    .turn_ok   (turn_ok),
    .up        (up),
    .down      (down),
    .left      (left),
    .right     (right),
    .pend_valid(pend_valid),
    .frame_err (frame_err)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if ({up, down, left, right, pend_valid, frame_err} !== mon_e.v) begin
        failures++;
        $display("FAIL %s: got up/dn/lf/rt/pend/ferr=%b expected %b", mon_e.name,
                 {up, down, left, right, pend_valid, frame_err}, mon_e.v);
      end
    end
  end

  // One clock of stimulus; the expectation is for the outputs after that edge
  task automatic step(input logic bv, input logic [7:0] d, input logic sd, input logic tok,
                      input logic [5:0] e, input string name);
    byte_valid = bv;
    byte_data  = d;
    step_done  = sd;
    turn_ok    = tok;
    @(posedge CLOCK_50);
    #1;
    exp_q.push_back('{v: e, name: name});
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    step_done  = 1'b0;
    turn_ok    = 1'b0;
  endtask

  task automatic do_reset(input string name);
    #5;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({up, down, left, right, pend_valid, frame_err} !== O_NO) begin
      failures++;
      $display("FAIL %s: got up/dn/lf/rt/pend/ferr=%b expected %b", name,
               {up, down, left, right, pend_valid, frame_err}, O_NO);
    end
    @(posedge CLOCK_50);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset("reset_state");
    step(1'b0, 8'h00, 1'b0, 1'b0, O_NO, "idle_after_reset");
  endtask

  task automatic test_make_from_stop();
    step(1'b1, 8'h1D, 1'b0, 1'b0, O_UP, "make_up_from_stop");
    step(1'b0, 8'h00, 1'b0, 1'b0, O_UP, "up_held");
  endtask

  task automatic test_ext_turn();
    step(1'b1, 8'hE0, 1'b0, 1'b0, O_UP, "ext_prefix");
    step(1'b1, 8'h74, 1'b0, 1'b0, O_UP | O_PV, "ext_right_pending");
    step(1'b0, 8'h00, 1'b0, 1'b0, O_UP | O_PV, "right_waits_for_tile");
    step(1'b0, 8'h00, 1'b1, 1'b1, O_RT, "step_commit_right");
  endtask

  task automatic test_blocked_turn();
    step(1'b1, 8'h1D, 1'b0, 1'b0, O_RT | O_PV, "up_requested");
    step(1'b0, 8'h00, 1'b1, 1'b0, O_RT | O_PV, "blocked_hold");
    step(1'b0, 8'h00, 1'b0, 1'b0, O_RT | O_PV, "blocked_retained");
    step(1'b0, 8'h00, 1'b1, 1'b1, O_UP, "unblocked_commit_up");
    step(1'b0, 8'h00, 1'b1, 1'b1, O_UP, "step_no_pending");
  endtask

  task automatic test_reversal();
    step(1'b1, 8'h1C, 1'b0, 1'b0, O_UP | O_PV, "left_requested");
    step(1'b0, 8'h00, 1'b1, 1'b1, O_LF, "commit_left");
    step(1'b1, 8'h23, 1'b0, 1'b0, O_RT, "reversal_right");
  endtask

  task automatic test_coincident();
    step(1'b1, 8'h1D, 1'b0, 1'b0, O_RT | O_PV, "req_up_before_step");
    step(1'b1, 8'h1B, 1'b1, 1'b1, O_UP | O_PV, "coincident_old_req");
    step(1'b0, 8'h00, 1'b1, 1'b1, O_DN, "later_commit_down");
  endtask

  task automatic test_release();
    step(1'b1, 8'h1D, 1'b0, 1'b0, O_UP, "reversal_up");
    step(1'b1, 8'hF0, 1'b0, 1'b0, O_UP, "brk_prefix");
    step(1'b1, 8'h1D, 1'b0, 1'b0, O_UP, "brk_up_ignored");
    step(1'b1, 8'hF0, 1'b0, 1'b0, O_UP, "brk_prefix2");
    step(1'b1, 8'h1B, 1'b0, 1'b0, O_UP, "brk_down_ignored");
    step(1'b1, 8'hE0, 1'b0, 1'b0, O_UP, "ext_brk_e0");
    step(1'b1, 8'hF0, 1'b0, 1'b0, O_UP, "ext_brk_f0");
    step(1'b1, 8'h72, 1'b0, 1'b0, O_UP, "ext_brk_ignored");
  endtask

  task automatic test_ignored();
    step(1'b1, 8'hFA, 1'b0, 1'b0, O_UP, "fa_ignored");
    step(1'b1, 8'hAA, 1'b0, 1'b0, O_UP, "aa_ignored");
    step(1'b1, 8'hE0, 1'b0, 1'b0, O_UP, "e0_before_12");
    step(1'b1, 8'h12, 1'b0, 1'b0, O_UP, "e0_12_ignored");
    step(1'b1, 8'h1B, 1'b0, 1'b0, O_DN, "idle_after_e0_12");
  endtask

  task automatic test_timeout();
    do_reset("reset_before_timeout");
    step(1'b1, 8'h1C, 1'b0, 1'b0, O_LF, "left_from_stop");
    step(1'b1, 8'hE0, 1'b0, 1'b0, O_LF, "e0_then_silence");
    for (int i = 1; i <= int'(TB_TIMEOUT) + 4; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, (i == int'(TB_TIMEOUT)) ? (O_LF | O_FE) : O_LF,
           "timeout_window");
    end
    step(1'b1, 8'h1B, 1'b0, 1'b0, O_LF | O_PV, "down_req_after_timeout");
  endtask

  task automatic test_reset_mid();
    step(1'b1, 8'h1D, 1'b0, 1'b0, O_LF | O_PV, "up_req_before_reset");
    step(1'b1, 8'hE0, 1'b0, 1'b0, O_LF | O_PV, "e0_before_reset");
    do_reset("reset_mid_sequence");
    step(1'b1, 8'h75, 1'b0, 1'b0, O_NO, "75_from_idle_ignored");
    step(1'b1, 8'h1D, 1'b0, 1'b0, O_UP, "up_after_reset");
  endtask

  initial begin
    test_reset();
    test_make_from_stop();
    test_ext_turn();
    test_blocked_turn();
    test_reversal();
    test_coincident();
    test_release();
    test_ignored();
    test_timeout();
    test_reset_mid();
    repeat (3) @(posedge CLOCK_50);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
